// File: rtl/rs232_pkg.sv
// rs232_pkg: FSM state type, baud constants, fsel encodings and the bit-period helper for rs232_txf.
// The RS232_TXF_PARITY_EN macro is consumed by rs232_txf; calc_parity is only referenced there.
package rs232_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  localparam int unsigned BAUD_115200 = 32'd115200;
  localparam int unsigned BAUD_57600  = 32'd57600;
  localparam int unsigned BAUD_38400  = 32'd38400;
  localparam int unsigned BAUD_19200  = 32'd19200;

  localparam logic [1:0] FSEL_115200 = 2'b00;
  localparam logic [1:0] FSEL_57600  = 2'b01;
  localparam logic [1:0] FSEL_38400  = 2'b10;
  localparam logic [1:0] FSEL_19200  = 2'b11;

  // Bit period in clock cycles, truncated.
  function automatic logic [15:0] calc_limit(input int unsigned clock_freq, input logic [1:0] fsel);
    int unsigned baud;
    case (fsel)
      FSEL_115200: baud = BAUD_115200;
      FSEL_57600:  baud = BAUD_57600;
      FSEL_38400:  baud = BAUD_38400;
      FSEL_19200:  baud = BAUD_19200;
      default:     baud = BAUD_19200;
    endcase
    return 16'(clock_freq / baud);
  endfunction

  function automatic logic calc_parity(input logic [7:0] data, input int unsigned nbits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
      else           p = p;
    end
    return p;
  endfunction

endpackage

// File: rtl/rs232_txf_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty/count; read data is the head entry.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr,
  input  logic [Width-1:0]         i_wr_data,
  input  logic                     i_rd,
  output logic [Width-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_count
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_full, r_empty;
  logic             w_do_wr, w_do_rd;
  logic [AW:0]      w_count_nxt;

  // Writes are gated by the registered full flag, so a write while full never lands.
  always_comb begin
    w_do_wr     = i_wr & ~r_full;
    w_do_rd     = i_rd & ~r_empty;
    w_count_nxt = r_count;
    if (w_do_wr && !w_do_rd)      w_count_nxt = r_count + (AW + 1)'(1);
    else if (!w_do_wr && w_do_rd) w_count_nxt = r_count - (AW + 1)'(1);
    else                          w_count_nxt = r_count;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/rs232_txf.sv
// rs232_txf: buffered RS232 transmitter, runtime baud/stop/parity latched per frame at pop.
// Define RS232_TXF_PARITY_EN to build the PARITY state; otherwise par_en/par_odd are ignored.
module rs232_txf
  import rs232_pkg::*;
#(
  parameter int unsigned ClockFreq = 50000000,
  parameter int unsigned DataBits  = 8,
  parameter int unsigned FifoDepth = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr,
  input  logic [7:0]                  i_data_in,
  input  logic [1:0]                  i_fsel,
  input  logic                        i_stop2,
  input  logic                        i_par_en,
  input  logic                        i_par_odd,
  output logic                        o_rdy,
  output logic                        o_empty,
  output logic                        o_busy,
  output logic [$clog2(FifoDepth):0]  o_count,
  output logic                        o_txd
);

  localparam logic [2:0] LAST_DATA = 3'(DataBits - 1);

  tx_state_e   r_state, w_state_nxt;
  logic [15:0] r_tick, r_limit;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_stop2, r_txd, r_busy;
  logic        w_fifo_empty, w_fifo_full, w_pop, w_tick_end;
  logic [7:0]  w_fifo_data;
`ifdef RS232_TXF_PARITY_EN
  logic        r_par_en, r_par_bit;
`else
  logic        w_unused_par;
  assign w_unused_par = i_par_en ^ i_par_odd;
`endif

  sync_fifo #(.Width(8), .Depth(FifoDepth)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr      (i_wr),
    .i_wr_data (i_data_in),
    .i_rd      (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (o_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; STOP reuses the bit counter to count one or two stop periods.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tick_end  = (r_tick == r_limit - 16'd1);
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_tick_end) w_state_nxt = S_DATA;
        else            w_state_nxt = S_START;
      end
      S_DATA: begin
        if (w_tick_end && (r_bit_cnt == LAST_DATA)) begin
`ifdef RS232_TXF_PARITY_EN
          w_state_nxt = r_par_en ? S_PARITY : S_STOP;
`else
          w_state_nxt = S_STOP;
`endif
        end else begin
          w_state_nxt = S_DATA;
        end
      end
`ifdef RS232_TXF_PARITY_EN
      S_PARITY: begin
        if (w_tick_end) w_state_nxt = S_STOP;
        else            w_state_nxt = S_PARITY;
      end
`endif
      S_STOP: begin
        if (w_tick_end && (r_bit_cnt[0] == r_stop2)) w_state_nxt = S_IDLE;
        else                                          w_state_nxt = S_STOP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tick    <= 16'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'hFF;
      r_limit   <= 16'd1;
      r_stop2   <= 1'b0;
`ifdef RS232_TXF_PARITY_EN
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
`endif
    end else begin
      if ((r_state == S_IDLE) || w_tick_end) r_tick <= 16'd0;
      else                                   r_tick <= r_tick + 16'd1;

      if (w_state_nxt != r_state) r_bit_cnt <= 3'd0;
      else if (w_tick_end)        r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_pop)                                 r_shift <= w_fifo_data;
      else if ((r_state == S_DATA) && w_tick_end) r_shift <= {1'b1, r_shift[7:1]};

      // Frame configuration is frozen here so mid-frame input changes do not disturb the line.
      if (w_pop) begin
        r_limit   <= calc_limit(ClockFreq, i_fsel);
        r_stop2   <= i_stop2;
`ifdef RS232_TXF_PARITY_EN
        r_par_en  <= i_par_en;
        r_par_bit <= calc_parity(w_fifo_data, DataBits, i_par_odd);
`endif
      end
    end
  end

  // Line driver: txd follows the state one cycle later, giving a glitch-free flop output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_txd  <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE:   r_txd <= 1'b1;
        S_START:  r_txd <= 1'b0;
        S_DATA:   r_txd <= r_shift[0];
`ifdef RS232_TXF_PARITY_EN
        S_PARITY: r_txd <= r_par_bit;
`endif
        S_STOP:   r_txd <= 1'b1;
        default:  r_txd <= 1'b1;
      endcase
    end
  end

  assign o_txd   = r_txd;
  assign o_busy  = r_busy;
  assign o_rdy   = ~w_fifo_full;
  assign o_empty = w_fifo_empty;

endmodule

// File: tb/tb_rs232_txf.sv
// tb_rs232_txf: directed + randomized bench; every cycle of txd/busy/rdy/empty/count is compared
// against a frame-level model (frame start times, FIFO occupancy, per-bit levels).
`timescale 1ns/1ps
module tb_rs232_txf;

  localparam int unsigned CLK_HZ = 1152000;
  localparam int unsigned DB     = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int MAXC = 32768;
  localparam int SEG  = 8192;
`ifdef RS232_TXF_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, wr, stop2, par_en, par_odd;
  logic [7:0] data_in;
  logic [1:0] fsel;
  logic       rdy, empty, busy, txd;
  logic [2:0] count;

  rs232_txf #(.ClockFreq(CLK_HZ), .DataBits(DB), .FifoDepth(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr(wr), .i_data_in(data_in), .i_fsel(fsel),
    .i_stop2(stop2), .i_par_en(par_en), .i_par_odd(par_odd),
    .o_rdy(rdy), .o_empty(empty), .o_busy(busy), .o_count(count), .o_txd(txd)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic       lg_wr[MAXC], lg_rst[MAXC], lg_stop2[MAXC], lg_pen[MAXC], lg_podd[MAXC];
  logic [7:0] lg_data[MAXC];
  logic [1:0] lg_fsel[MAXC];
  logic       ob_txd[MAXC], ob_busy[MAXC], ob_rdy[MAXC], ob_empty[MAXC];
  logic [2:0] ob_cnt[MAXC];
  logic       ex_txd[MAXC], ex_busy[MAXC], ex_rdy[MAXC], ex_empty[MAXC];
  logic [2:0] ex_cnt[MAXC];

  // Inputs as seen by the DUT at each rising edge.
  initial forever begin
    @(posedge clk);
    if (ecnt < MAXC - 1) ecnt++;
    lg_wr[ecnt] = wr;     lg_rst[ecnt] = rst;     lg_data[ecnt] = data_in;
    lg_fsel[ecnt] = fsel; lg_stop2[ecnt] = stop2; lg_pen[ecnt] = par_en; lg_podd[ecnt] = par_odd;
  end

  // Outputs in the cycle following each rising edge.
  initial forever begin
    @(negedge clk);
    ob_txd[ecnt] = txd; ob_busy[ecnt] = busy; ob_rdy[ecnt] = rdy;
    ob_empty[ecnt] = empty; ob_cnt[ecnt] = count;
  end

  function automatic int baud_of(input logic [1:0] f);
    case (f)
      2'd0:    return 115200;
      2'd1:    return 57600;
      2'd2:    return 38400;
      default: return 19200;
    endcase
  endfunction

  // Frame-level model: a frame starts at max(write+2, previous end+1) and uses the config
  // present at its pop edge (start-1); a write is dropped when the FIFO already holds DEPTH.
  task automatic run_model(input int s, input int e);
    int wq[$], pq[$], stq[$], lenq[$], limq[$];
    logic [7:0] dq[$];
    bit hpq[$], pvq[$];
    int rst_at, earliest;
    rst_at = e + 1;
    earliest = 0;
    for (int c = s + 1; c <= e; c++) if (lg_rst[c] === 1'b1 && rst_at > e) rst_at = c;
    for (int c = s + 1; c < rst_at; c++) begin
      int occ, st, pe, lim, nb;
      bit hp, pv;
      if (lg_wr[c] === 1'b1) begin
        occ = 0;
        foreach (wq[k]) if (wq[k] < c && pq[k] >= c) occ++;
        if (occ < DEPTH) begin
          st  = (c + 2 > earliest) ? c + 2 : earliest;
          pe  = st - 1;
          lim = CLK_HZ / baud_of(lg_fsel[pe]);
          hp  = PAR_BUILD && lg_pen[pe];
          pv  = lg_podd[pe];
          for (int i = 0; i < DB; i++) pv = pv ^ lg_data[c][i];
          nb  = 1 + DB + (hp ? 1 : 0) + (lg_stop2[pe] ? 2 : 1);
          wq.push_back(c); pq.push_back(pe); stq.push_back(st); lenq.push_back(nb * lim);
          limq.push_back(lim); dq.push_back(lg_data[c]); hpq.push_back(hp); pvq.push_back(pv);
          earliest = st + nb * lim + 1;
        end
      end
    end
    for (int c = s; c <= e; c++) begin
      int n, b;
      n = 0;
      ex_txd[c] = 1'b1;
      ex_busy[c] = 1'b0;
      foreach (wq[k]) begin
        if (wq[k] <= c && pq[k] > c) n++;
        if (c >= stq[k] && c < stq[k] + lenq[k]) begin
          b = (c - stq[k]) / limq[k];
          ex_busy[c] = 1'b1;
          if (b == 0)                     ex_txd[c] = 1'b0;
          else if (b <= DB)               ex_txd[c] = dq[k][b-1];
          else if (b == DB + 1 && hpq[k]) ex_txd[c] = pvq[k];
          else                            ex_txd[c] = 1'b1;
        end
      end
      if (c >= rst_at) begin
        n = 0;
        ex_txd[c] = 1'b1;
        ex_busy[c] = 1'b0;
      end
      ex_cnt[c]   = 3'(n);
      ex_empty[c] = (n == 0);
      ex_rdy[c]   = (n < DEPTH);
    end
  endtask

  task automatic check_seg(input string tag, input int s, input int e);
    logic [SEG-1:0]   ot, et, ob, eb, orr, er, oe, ee;
    logic [3*SEG-1:0] oc, ec;
    int ft, fb, fr, fe, fc;
    if (e - s + 1 > SEG || e >= MAXC - 1) begin
      n_chk++; n_fail++;
      $display("FAIL %s segment bounds s=%0d e=%0d", tag, s, e);
      return;
    end
    run_model(s, e);
    ot = '0; et = '0; ob = '0; eb = '0; orr = '0; er = '0; oe = '0; ee = '0; oc = '0; ec = '0;
    ft = -1; fb = -1; fr = -1; fe = -1; fc = -1;
    for (int c = s; c <= e; c++) begin
      ot[c-s] = ob_txd[c];   et[c-s] = ex_txd[c];
      ob[c-s] = ob_busy[c];  eb[c-s] = ex_busy[c];
      orr[c-s] = ob_rdy[c];  er[c-s] = ex_rdy[c];
      oe[c-s] = ob_empty[c]; ee[c-s] = ex_empty[c];
      oc[3*(c-s) +: 3] = ob_cnt[c]; ec[3*(c-s) +: 3] = ex_cnt[c];
      if (ft < 0 && ob_txd[c] !== ex_txd[c])     ft = c;
      if (fb < 0 && ob_busy[c] !== ex_busy[c])   fb = c;
      if (fr < 0 && ob_rdy[c] !== ex_rdy[c])     fr = c;
      if (fe < 0 && ob_empty[c] !== ex_empty[c]) fe = c;
      if (fc < 0 && ob_cnt[c] !== ex_cnt[c])     fc = c;
    end
    n_chk++;
    assert (ot === et) n_pass++;
    else begin n_fail++; $error("FAIL %s_txd cycle %0d got %b want %b", tag, ft, ob_txd[ft], ex_txd[ft]); end
    n_chk++;
    assert (ob === eb) n_pass++;
    else begin n_fail++; $error("FAIL %s_busy cycle %0d got %b want %b", tag, fb, ob_busy[fb], ex_busy[fb]); end
    n_chk++;
    assert (orr === er) n_pass++;
    else begin n_fail++; $error("FAIL %s_rdy cycle %0d got %b want %b", tag, fr, ob_rdy[fr], ex_rdy[fr]); end
    n_chk++;
    assert (oe === ee) n_pass++;
    else begin n_fail++; $error("FAIL %s_empty cycle %0d got %b want %b", tag, fe, ob_empty[fe], ex_empty[fe]); end
    n_chk++;
    assert (oc === ec) n_pass++;
    else begin n_fail++; $error("FAIL %s_count cycle %0d got %0d want %0d", tag, fc, ob_cnt[fc], ex_cnt[fc]); end
  endtask

  task automatic chk1(input string tag, input int got, input int want);
    n_chk++;
    assert (got === want) n_pass++;
    else begin n_fail++; $error("FAIL %s got %0d want %0d", tag, got, want); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input logic [7:0] d);
    wr = 1'b1; data_in = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic seg_end(input string tag, input int s);
    @(negedge clk);
    #1;
    check_seg(tag, s, ecnt);
  endtask

  task automatic rand_cfg();
    fsel = 2'($urandom_range(3, 0)); stop2 = 1'($urandom);
    par_en = 1'($urandom); par_odd = 1'($urandom);
  endtask

  initial begin
    int s, nw, gap;
    rst = 1'b1; wr = 1'b0; data_in = 8'h00; fsel = 2'b00; stop2 = 1'b0; par_en = 1'b0; par_odd = 1'b0;
    idle(3);
    chk1("rst_txd", int'(txd), 1);
    chk1("rst_rdy", int'(rdy), 1);
    chk1("rst_empty", int'(empty), 1);
    chk1("rst_busy", int'(busy), 0);
    chk1("rst_count", int'(count), 0);
    rst = 1'b0;
    s = ecnt; idle(100); seg_end("idle", s);

    tick(); s = ecnt;
    write(8'h55); idle(120); seg_end("frame55", s);

    tick(); s = ecnt;
    for (int i = 0; i < 6; i++) write(8'($urandom));
    chk1("burst_count", int'(count), 4);
    chk1("burst_rdy", int'(rdy), 0);
    idle(5 * 101 + 20); seg_end("burst", s);

    tick(); s = ecnt;
    fsel = 2'b11; stop2 = 1'b1; par_en = 1'b1; par_odd = 1'b0;
    write(8'h07); idle(760); seg_end("parity", s);
    fsel = 2'b00; stop2 = 1'b0; par_en = 1'b0;

    tick(); s = ecnt;
    write(8'hA3); write(8'h3C); idle(30);
    fsel = 2'b11; idle(800); seg_end("fsel_mid", s);
    fsel = 2'b00;

    tick(); s = ecnt;
    write(8'h96); write(8'h11); write(8'h22); idle(40);
    rst = 1'b1; tick();
    chk1("mid_rst_txd", int'(txd), 1);
    chk1("mid_rst_count", int'(count), 0);
    chk1("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    idle(200); seg_end("mid_rst", s);

    for (int r = 0; r < 4; r++) begin
      tick(); s = ecnt;
      nw = $urandom_range(7, 1);
      for (int i = 0; i < nw; i++) begin
        rand_cfg();
        write(8'($urandom));
        gap = $urandom_range(3, 0);
        for (int j = 0; j < gap; j++) begin rand_cfg(); tick(); end
      end
      for (int j = 0; j < 3700; j++) begin rand_cfg(); tick(); end
      seg_end($sformatf("rand%0d", r), s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rs232_txf.md
# rs232_txf

Buffered, parametrised RS232 transmitter: next generation of the fixed 8N1 transmitter, adding a write FIFO, four runtime baud rates, 5–8 data bits, 1 or 2 stop bits and optional parity. Sits between the I/O register decoder and the TXD pin; software writes bytes back-to-back until `rdy` drops instead of polling per byte.

## Interface
- `ClockFreq`, 50000000: clock frequency in Hz; `ClockFreq/19200` must be < 65536.
- `DataBits`, 8: data bits per frame, 5..8; `data_in` bits above `DataBits-1` are ignored.
- `FifoDepth`, 16: FIFO entries, power of two, ≥ 2.

- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `wr`  in  1  write strobe; enqueues `data_in` when `rdy`=1.
- `data_in`  in  8  byte to send, LSB first.
- `fsel`  in  2  baud select: 00=115200, 01=57600, 10=38400, 11=19200.
- `stop2`  in  1  1 = two stop bits.
- `par_en`  in  1  parity enable (macro-dependent).
- `par_odd`  in  1  1 = odd parity, 0 = even.
- `rdy`  out  1  FIFO not full.
- `empty`  out  1  FIFO empty.
- `busy`  out  1  frame in progress (FSM not IDLE).
- `count`  out  $clog2(FifoDepth)+1  FIFO occupancy.
- `txd`  out  1  serial line, idle high.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `txd`=1. If FIFO non-empty: pop head into shift register, latch `fsel`/`stop2`/`par_en`/`par_odd`, go START. Config inputs changing mid-frame have no effect on the current frame.
- START: `txd`=0 for one bit period → DATA.
- DATA: `DataBits` bits, LSB first, one bit period each → PARITY if latched `par_en`, else STOP.
- PARITY: `txd` = XOR of the `DataBits` sent, inverted if `par_odd` → STOP.
- STOP: `txd`=1 for 1 or 2 bit periods → IDLE.
- Bit period = `limit` cycles exactly; `limit` = `ClockFreq/baud`, truncated; tick counter 16 bits, counts 0..limit-1.
- Write when full: dropped, no state change. Simultaneous write and pop: both occur, `count` unchanged.
- `rst`: FIFO emptied, FSM to IDLE, counters cleared, mid-frame output aborted.
- Reset values: `txd`=1, `rdy`=1, `empty`=1, `busy`=0, `count`=0.

## Timing
- Write accepted on edge N → `count`/`empty` update after edge N.
- FSM in IDLE with non-empty FIFO pops on the next edge; `txd`=0 from the second edge after the write (write-to-start-bit latency 2 cycles).
- Frame length, in bit periods: 1 + `DataBits` + parity(0/1) + stop(1/2).
- Back-to-back frames: at the end of STOP the FSM spends exactly one cycle in IDLE (`txd`=1) before the next START.
- `rdy` reasserts the cycle after the pop that frees a slot.
- Outputs registered; `txd` glitch-free.

## Configuration
- `RS232_TXF_PARITY_EN` defined: PARITY state and `par_en`/`par_odd` functional.
- Not defined: ports remain but are ignored; PARITY state and parity logic not synthesised; frames never carry a parity bit.

## Structure
- Package `rs232_pkg`: FSM state enum, baud-rate constants (115200, 57600, 38400, 19200), `fsel` encodings, a function computing `limit` from `ClockFreq` and `fsel`.
- Sub-module `sync_fifo` (parametrised width/depth, registered outputs, full/empty/count); `rs232_txf` holds FSM, tick counter, bit counter and shift register.

## Test plan
(`ClockFreq`=1152000 → limits 10/20/30/60; `DataBits`=8; `FifoDepth`=4)
- Reset, then idle 100 cycles → `txd`=1, `rdy`=1, `empty`=1, `busy`=0, `count`=0 throughout.
- Write 0x55, `fsel`=00, `stop2`=0, `par_en`=0 → `txd` low from 2nd cycle after write; bits 1,0,1,0,1,0,1,0, then stop; each level exactly 10 cycles; frame 100 cycles; `busy` falls after stop.
- Write 6 bytes in 6 consecutive cycles → first 5 accepted (1 popped + 4 buffered), 6th dropped; `rdy`=0 once full; 5 frames sent, each separated by one idle cycle.
- Macro defined, write 0x07, `par_en`=1, `par_odd`=0, `fsel`=11, `stop2`=1 → parity bit 1; two stop bits; every level 60 cycles; frame 12×60 cycles.
- `fsel` changed from 00 to 11 mid-frame → current frame stays 10 cycles/bit; next frame 60 cycles/bit.
- `rst` asserted mid-DATA with 2 bytes queued → next cycle `txd`=1, `count`=0, `busy`=0; no further frames.
